// File: rtl/data_mem_access_unit_pkg.sv
// Shared load/store encodings: access widths, sequencer states and funct3 decode.
package data_mem_access_unit_pkg;

  localparam logic [3:0] MEM_W_BYTE = 4'd1;
  localparam logic [3:0] MEM_W_HALF = 4'd2;
  localparam logic [3:0] MEM_W_WORD = 4'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  typedef struct packed {
    logic [3:0] width;
    logic       load_unsigned;
    logic       legal;
  } mem_size_t;

  // Same mapping the control generator uses to derive width/extension from funct3.
  function automatic mem_size_t funct3_to_size(input logic [2:0] funct3);
    mem_size_t s;
    s.load_unsigned = funct3[2];
    s.legal         = 1'b1;
    case (funct3[1:0])
      2'b00:   s.width = MEM_W_BYTE;
      2'b01:   s.width = MEM_W_HALF;
      2'b10:   s.width = MEM_W_WORD;
      default: begin
        s.width = 4'd0;
        s.legal = 1'b0;
      end
    endcase
    if (funct3 == 3'b110) s.legal = 1'b0;
    return s;
  endfunction

  function automatic logic width_legal(input logic [3:0] w);
    return (w == MEM_W_BYTE) || (w == MEM_W_HALF) || (w == MEM_W_WORD);
  endfunction

endpackage

// File: rtl/data_mem_access_unit_lane_align.sv
// Byte-lane steering for both bus beats and load merge/extension.
module mem_lane_align
  import data_mem_access_unit_pkg::*;
(
  input  logic [3:0]  width_i,
  input  logic [1:0]  off_i,
  input  logic        load_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] beat0_i,
  input  logic [31:0] beat1_i,
  output logic [3:0]  be0_o,
  output logic [3:0]  be1_o,
  output logic [31:0] wdata0_o,
  output logic [31:0] wdata1_o,
  output logic [31:0] load_data_o
);

  logic [3:0]  mask;
  logic [7:0]  be_sh;
  logic [63:0] wd_sh;
  logic [63:0] rd_sh;
  logic [31:0] raw;

  // A 64-bit view of two consecutive words makes the split beat the upper half.
  always_comb begin
    case (width_i)
      MEM_W_BYTE: mask = 4'b0001;
      MEM_W_HALF: mask = 4'b0011;
      default:    mask = 4'b1111;
    endcase
    be_sh = {4'b0000, mask} << off_i;
    wd_sh = {32'h0, wdata_i} << {off_i, 3'b000};
    rd_sh = {beat1_i, beat0_i} >> {off_i, 3'b000};
    raw   = rd_sh[31:0];
    case (width_i)
      MEM_W_BYTE: load_data_o = {{24{~load_unsigned_i & raw[7]}}, raw[7:0]};
      MEM_W_HALF: load_data_o = {{16{~load_unsigned_i & raw[15]}}, raw[15:0]};
      default:    load_data_o = raw;
    endcase
  end

  assign be0_o    = be_sh[3:0];
  assign be1_o    = be_sh[7:4];
  assign wdata0_o = wd_sh[31:0];
  assign wdata1_o = wd_sh[63:32];

endmodule

// File: rtl/data_mem_access_unit.sv
// Load/store sequencer: splits unaligned accesses into word beats on a req/ack bus.
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  write_en,
  input  logic [3:0]            width,
  input  logic                  load_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           rdata,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_byte_en,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata
);

  localparam int unsigned CNT_W = 32;

  logic [1:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [3:0]            width_q, width_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           beat0_q, beat0_d;
  logic [31:0]           beat1_q, beat1_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  split;
  logic                  timeout_hit;
  logic                  in_beat;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [3:0]            be0, be1;
  logic [31:0]           wd0, wd1, load_data;

  assign split       = (5'(addr_q[1:0]) + 5'(width_q)) > 5'd4;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign base_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  mem_lane_align u_align (
    .width_i         (width_q),
    .off_i           (addr_q[1:0]),
    .load_unsigned_i (uns_q),
    .wdata_i         (wdata_q),
    .beat0_i         (beat0_q),
    .beat1_i         (beat1_q),
    .be0_o           (be0),
    .be1_o           (be1),
    .wdata0_o        (wd0),
    .wdata1_o        (wd1),
    .load_data_o     (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      width_q <= 4'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      beat0_q <= 32'h0;
      beat1_q <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat0_q <= beat0_d;
      beat1_q <= beat1_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Per-beat wait counter restarts on every beat entry; an ack wins over a timeout.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    width_d = width_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat0_d = beat0_q;
    beat1_d = beat1_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = write_en;
          width_d = width;
          uns_d   = load_unsigned;
          addr_d  = addr;
          wdata_d = wdata;
          beat0_d = 32'h0;
          beat1_d = 32'h0;
          cnt_d   = '0;
          err_d   = !width_legal(width);
          state_d = width_legal(width) ? ST_BEAT0 : ST_RESP;
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (bus_ack) begin
          if (state_q == ST_BEAT0) beat0_d = bus_rdata;
          else                     beat1_d = bus_rdata;
          cnt_d   = '0;
          state_d = (state_q == ST_BEAT0 && split) ? ST_BEAT1 : ST_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_beat     = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign req_ready   = (state_q == ST_IDLE);
  assign bus_req     = in_beat;
  assign bus_we      = in_beat & we_q;
  assign bus_addr    = (state_q == ST_BEAT0) ? base_addr :
                       (state_q == ST_BEAT1) ? base_addr + ADDR_WIDTH'(4) : '0;
  assign bus_byte_en = (state_q == ST_BEAT0) ? be0 : (state_q == ST_BEAT1) ? be1 : 4'b0000;
  assign bus_wdata   = (state_q == ST_BEAT0) ? wd0 : (state_q == ST_BEAT1) ? wd1 : 32'h0;
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_err    = (state_q == ST_RESP) & err_q;
  assign rdata       = (state_q == ST_RESP && !we_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench: bus beats and responses are queued at issue and checked by monitors.
module tb_data_mem_access_unit;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  typedef struct packed {
    logic [7:0]  waits;
    logic [31:0] rd;
  } brsp_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
    logic [7:0]  lat;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, write_en, load_unsigned;
  logic [3:0]  width;
  logic [31:0] addr, wdata;
  logic        resp_valid, resp_err;
  logic [31:0] rdata;
  logic        bus_req, bus_ack, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byte_en;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int breq_cnt = 0;

  beat_t beat_q[$];
  brsp_t rsp_q[$];
  resp_t exp_q[$];

  data_mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .write_en(write_en), .width(width), .load_unsigned(load_unsigned),
    .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .rdata(rdata), .bus_req(bus_req), .bus_ack(bus_ack), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byte_en(bus_byte_en), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Bus slave: serves queued wait/data per beat and checks the beat it acks.
  brsp_t cur;
  logic  active = 1'b0;
  always @(negedge clk) begin
    if (rst || !bus_req) begin
      bus_ack = 1'b0;
      active  = 1'b0;
    end else begin
      breq_cnt = breq_cnt + 1;
      if (!active) begin
        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
        else cur = '{waits: 8'hff, rd: 32'h0};
        active = 1'b1;
      end
      if (cur.waits == 8'd0) begin
        bus_ack   = 1'b1;
        bus_rdata = cur.rd;
        active    = 1'b0;
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'(bus_addr), 32'hffff_ffff);
        end else begin
          beat_t e;
          e = beat_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(e.we));
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_byte_en", 32'(bus_byte_en), 32'(e.be));
          chk("bus_wdata", bus_wdata, e.wd);
        end
      end else begin
        cur.waits = cur.waits - 8'd1;
        bus_ack   = 1'b0;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'h0);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("rdata", rdata, e.rd);
        chk("latency", 32'(cyc - accept_cyc), 32'(e.lat));
      end
    end
  end

  task automatic add_beat(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [7:0] waits, input logic [31:0] rd);
    beat_q.push_back('{we: we, addr: a, be: be, wd: wd});
    rsp_q.push_back('{waits: waits, rd: rd});
  endtask

  task automatic add_resp(input logic err, input logic [31:0] rd, input logic [7:0] lat);
    exp_q.push_back('{err: err, rd: rd, lat: lat});
  endtask

  task automatic issue(input logic we, input logic [3:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; write_en = we; width = w; load_unsigned = uns; addr = a; wdata = wd;
    accept_cyc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk({nm, "_resp_drained"}, 32'(exp_q.size()), 32'h0);
    chk({nm, "_beats_drained"}, 32'(beat_q.size()), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    rst = 1'b0; req_valid = 1'b0; write_en = 1'b0; width = 4'd0; load_unsigned = 1'b0;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_byte_en", 32'(bus_byte_en), 32'h0);
    rst = 1'b0;

    // LW aligned, zero wait
    add_beat(1'b0, 32'h100, 4'b1111, 32'h0, 8'd0, 32'hDEAD_BEEF);
    add_resp(1'b0, 32'hDEAD_BEEF, 8'd2);
    issue(1'b0, 4'd4, 1'b0, 32'h100, 32'h0);
    drain("lw");

    // LB signed / unsigned on top byte lane
    add_beat(1'b0, 32'h100, 4'b1000, 32'h0, 8'd0, 32'h8012_3456);
    add_resp(1'b0, 32'hFFFF_FF80, 8'd2);
    issue(1'b0, 4'd1, 1'b0, 32'h103, 32'h0);
    drain("lb");
    add_beat(1'b0, 32'h100, 4'b1000, 32'h0, 8'd0, 32'h8012_3456);
    add_resp(1'b0, 32'h0000_0080, 8'd2);
    issue(1'b0, 4'd1, 1'b1, 32'h103, 32'h0);
    drain("lbu");

    // SW split across words
    add_beat(1'b1, 32'h100, 4'b1100, 32'h3344_0000, 8'd0, 32'h0);
    add_beat(1'b1, 32'h104, 4'b0011, 32'h0000_1122, 8'd0, 32'h0);
    add_resp(1'b0, 32'h0, 8'd3);
    issue(1'b1, 4'd4, 1'b0, 32'h102, 32'h1122_3344);
    drain("sw_split");

    // LH split with three wait states on the second beat
    add_beat(1'b0, 32'h200, 4'b1000, 32'h0, 8'd0, 32'hAB00_0000);
    add_beat(1'b0, 32'h204, 4'b0001, 32'h0, 8'd3, 32'h0000_00CD);
    add_resp(1'b0, 32'hFFFF_CDAB, 8'd6);
    issue(1'b0, 4'd2, 1'b0, 32'h203, 32'h0);
    drain("lh_split");

    // SB and LHU mid-word
    add_beat(1'b1, 32'h100, 4'b0010, 32'h0000_A500, 8'd0, 32'h0);
    add_resp(1'b0, 32'h0, 8'd2);
    issue(1'b1, 4'd1, 1'b0, 32'h101, 32'h0000_00A5);
    drain("sb");
    add_beat(1'b0, 32'h400, 4'b1100, 32'h0, 8'd1, 32'hBEEF_0000);
    add_resp(1'b0, 32'h0000_BEEF, 8'd3);
    issue(1'b0, 4'd2, 1'b1, 32'h402, 32'h0);
    drain("lhu");

    // LH split across the top of the address space
    add_beat(1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 8'd0, 32'h3400_0000);
    add_beat(1'b0, 32'h0000_0000, 4'b0001, 32'h0, 8'd0, 32'h0000_0012);
    add_resp(1'b0, 32'h0000_1234, 8'd3);
    issue(1'b0, 4'd2, 1'b0, 32'hFFFF_FFFF, 32'h0);
    drain("wrap");

    // Illegal width: error response, no bus traffic
    b = breq_cnt;
    add_resp(1'b1, 32'h0, 8'd1);
    issue(1'b0, 4'd3, 1'b0, 32'h100, 32'h0);
    drain("illegal");
    chk("illegal_bus_cycles", 32'(breq_cnt - b), 32'h0);

    // Bus never acks: timeout after four request cycles
    b = breq_cnt;
    rsp_q.push_back('{waits: 8'd200, rd: 32'h0});
    add_resp(1'b1, 32'h0, 8'd5);
    issue(1'b0, 4'd4, 1'b0, 32'h300, 32'h0);
    drain("timeout");
    chk("timeout_bus_cycles", 32'(breq_cnt - b), 32'h4);

    // Reset while the second beat of a split store is waiting
    add_beat(1'b1, 32'h104, 4'b1100, 32'hCCDD_0000, 8'd0, 32'h0);
    rsp_q.push_back('{waits: 8'd3, rd: 32'h0});
    issue(1'b1, 4'd4, 1'b0, 32'h106, 32'hAABB_CCDD);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_bus_addr", bus_addr, 32'h108);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_q.delete();
    repeat (6) @(negedge clk);
    chk("rst_no_beats_left", 32'(beat_q.size()), 32'h0);

    // Normal access after reset
    add_beat(1'b0, 32'h0, 4'b1111, 32'h0, 8'd0, 32'h1234_5678);
    add_resp(1'b0, 32'h1234_5678, 8'd2);
    issue(1'b0, 4'd4, 1'b0, 32'h0, 32'h0);
    drain("post_rst_lw");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
